// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions, FSM encoding and register-file
// addresses for the alu_seq execute unit.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;
  localparam logic [3:0] OP_CMP = 4'd12;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam int ACC_ADDR = 2;
  localparam int R0_ADDR  = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_WR_LO = 2'd2,
    S_WR_HI = 2'd3
  } state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per step_i.
// res_nxt_o is the {hi, lo} pair the current step will produce.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] res_nxt_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q;
  logic             div_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shl;
  logic [WIDTH-1:0] rem_sub;

  // Multiply: {hi, lo} is the partial product, lo shifts the multiplier out.
  // Divide: hi is the running remainder, lo shifts dividend out and quotient in.
  always_comb begin
    add_sum = {1'b0, hi_q} + {1'b0, opnd_q};
    mul_sum = lo_q[0] ? add_sum : {1'b0, hi_q};
    rem_shl = {hi_q, lo_q[WIDTH-1]};
    rem_sub = rem_shl[WIDTH-1:0] - opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (div_q) begin
      if (rem_shl >= {1'b0, opnd_q}) begin
        hi_d = rem_sub;
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = rem_shl[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign res_nxt_o = {hi_d, lo_d};
  assign last_o    = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (load_i) begin
      hi_q   <= '0;
      lo_q   <= a_i;
      opnd_q <= b_i;
      div_q  <= div_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Execute unit: single-cycle ops write ACC one cycle after start; MUL/DIV
// iterate 8 steps then write ACC and R0. Starts while busy are dropped.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RF_ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_start,
  input  logic [3:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_a,
  input  logic [WIDTH-1:0]     alu_b,
  output logic                 alu_busy,
  output logic                 alu_done,
  output logic [WIDTH-1:0]     alu_wr_data,
  output logic [RF_ADDR_W-1:0] alu_wr_addr,
  output logic                 alu_wr_en,
  output logic [3:0]           alu_flags,
  output logic                 alu_acc_zero,
  output logic                 alu_err
);

  state_e               state_q;
  logic [3:0]           op_q;
  logic                 dz_q;
  logic [WIDTH-1:0]     md_hi_q;
  logic [3:0]           pend_flags_q;
  logic                 busy_q, done_q, wr_en_q, err_q, acc_zero_q;
  logic [WIDTH-1:0]     wr_data_q;
  logic [RF_ADDR_W-1:0] wr_addr_q;
  logic [3:0]           flags_q;

  logic                 md_load, md_step, md_last;
  logic [2*WIDTH-1:0]   md_res;
  logic [WIDTH-1:0]     md_lo, md_hi;
  logic [3:0]           md_flags;

  logic [WIDTH-1:0]     opb;
  logic [WIDTH:0]       add_s, sub_s;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_c, sc_v, sc_wr, sc_upd;
  logic [3:0]           sc_flags;

  assign md_load = (state_q == S_IDLE) && alu_start && is_muldiv(alu_op);
  assign md_step = (state_q == S_ITER);

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .load_i    (md_load),
    .step_i    (md_step),
    .div_i     (alu_op == OP_DIV),
    .a_i       (alu_a),
    .b_i       (alu_b),
    .last_o    (md_last),
    .res_nxt_o (md_res)
  );

  assign md_lo = md_res[WIDTH-1:0];
  assign md_hi = md_res[2*WIDTH-1:WIDTH];

  always_comb begin
    md_flags         = '0;
    md_flags[FLAG_Z] = (md_lo == '0);
    md_flags[FLAG_N] = md_lo[WIDTH-1];
    md_flags[FLAG_C] = (op_q == OP_MUL) && (md_hi != '0);
    md_flags[FLAG_V] = (op_q == OP_MUL) ? (md_hi != '0) : dz_q;
  end

  // Single-cycle ops are evaluated straight from the operand ports so the
  // result is registered at the start edge.
  always_comb begin
    opb    = ((alu_op == OP_INC) || (alu_op == OP_DEC)) ? WIDTH'(1) : alu_b;
    add_s  = {1'b0, alu_a} + {1'b0, opb};
    sub_s  = {1'b0, alu_a} - {1'b0, opb};
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_wr  = 1'b1;
    sc_upd = 1'b1;
    case (alu_op)
      OP_ADD, OP_INC: begin
        sc_res = add_s[WIDTH-1:0];
        sc_c   = add_s[WIDTH];
        sc_v   = (alu_a[WIDTH-1] == opb[WIDTH-1]) && (sc_res[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_SUB, OP_DEC, OP_CMP: begin
        sc_res = sub_s[WIDTH-1:0];
        sc_c   = sub_s[WIDTH];
        sc_v   = (alu_a[WIDTH-1] != opb[WIDTH-1]) && (sc_res[WIDTH-1] != alu_a[WIDTH-1]);
        sc_wr  = (alu_op != OP_CMP);
      end
      OP_AND: sc_res = alu_a & alu_b;
      OP_OR:  sc_res = alu_a | alu_b;
      OP_XOR: sc_res = alu_a ^ alu_b;
      OP_NOT: sc_res = ~alu_a;
      OP_SHL: begin
        sc_res = {alu_a[WIDTH-2:0], 1'b0};
        sc_c   = alu_a[WIDTH-1];
      end
      OP_SHR: begin
        sc_res = {1'b0, alu_a[WIDTH-1:1]};
        sc_c   = alu_a[0];
      end
      default: begin
        sc_wr  = 1'b0;
        sc_upd = 1'b0;
      end
    endcase
    sc_flags         = '0;
    sc_flags[FLAG_Z] = (sc_res == '0);
    sc_flags[FLAG_C] = sc_c;
    sc_flags[FLAG_N] = sc_res[WIDTH-1];
    sc_flags[FLAG_V] = sc_v;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      dz_q         <= 1'b0;
      md_hi_q      <= '0;
      pend_flags_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      err_q        <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      flags_q      <= '0;
      acc_zero_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (alu_start) begin
            op_q   <= alu_op;
            dz_q   <= (alu_b == '0);
            busy_q <= 1'b1;
            if (is_muldiv(alu_op)) begin
              state_q <= S_ITER;
            end else begin
              state_q   <= S_WR_LO;
              done_q    <= 1'b1;
              wr_en_q   <= sc_wr;
              wr_data_q <= sc_res;
              wr_addr_q <= RF_ADDR_W'(ACC_ADDR);
              if (sc_wr)  acc_zero_q <= (sc_res == '0);
              if (sc_upd) flags_q    <= sc_flags;
            end
          end
        end
        S_ITER: begin
          if (md_last) begin
            state_q      <= S_WR_LO;
            wr_en_q      <= 1'b1;
            wr_data_q    <= md_lo;
            wr_addr_q    <= RF_ADDR_W'(ACC_ADDR);
            acc_zero_q   <= (md_lo == '0);
            md_hi_q      <= md_hi;
            pend_flags_q <= md_flags;
          end
        end
        S_WR_LO: begin
          if (is_muldiv(op_q)) begin
            state_q   <= S_WR_HI;
            wr_en_q   <= 1'b1;
            wr_data_q <= md_hi_q;
            wr_addr_q <= RF_ADDR_W'(R0_ADDR);
            done_q    <= 1'b1;
            err_q     <= (op_q == OP_DIV) && dz_q;
            flags_q   <= pend_flags_q;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign alu_busy     = busy_q;
  assign alu_done     = done_q;
  assign alu_wr_en    = wr_en_q;
  assign alu_wr_data  = wr_data_q;
  assign alu_wr_addr  = wr_addr_q;
  assign alu_flags    = flags_q;
  assign alu_acc_zero = acc_zero_q;
  assign alu_err      = err_q;

endmodule
